bcd_down_counter: RTL and testbench

- Two-digit BCD modulo-N counter whose primary direction is down.
- Counterpart to the hours/minutes up-counters: used for countdown timers and alarm-offset chains.
- Emits a registered one-cycle borrow pulse on wrap, so stages cascade by tying one stage's borrow into the next stage's en.
- Supports synchronous BCD load with range checking, so software/UI can preset the count.

---
 rtl/bcd_pkg.sv | 15 +
 rtl/delay_ff.sv | 20 ++
 rtl/bcd_down_counter.sv | 110 +++++++++++
 tb/tb_bcd_down_counter.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared BCD types and helpers for the clock/timer counter family.
package bcd_pkg;

    typedef logic [3:0] bcd_digit_t;

    function automatic logic is_bcd(input bcd_digit_t d);
        return (d <= 4'd9);
    endfunction

    // Wide enough for out-of-range digits (15*10+15) so range checks never overflow.
    function automatic logic [7:0] bcd_to_bin(input bcd_digit_t tens, input bcd_digit_t ones);
        return ({4'd0, tens} * 8'd10) + {4'd0, ones};
    endfunction

endpackage

// File: rtl/delay_ff.sv
// One-cycle register stage with asynchronous active-high clear.
module delay_ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Capture d on every rising edge; clear immediately on reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/bcd_down_counter.sv
// Two-digit BCD modulo-MODULUS counter, down by default, with range-checked load
// and registered borrow / load_err pulses for cascading.
module bcd_down_counter
    import bcd_pkg::*;
#(
    parameter int MODULUS = 24
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       inc,
    input  logic       load,
    input  logic [3:0] load_ones,
    input  logic [3:0] load_tens,
    output logic [3:0] ones,
    output logic [3:0] tens,
    output logic       borrow,
    output logic       load_err
);

    localparam bcd_digit_t WRAP_TENS = bcd_digit_t'((MODULUS - 1) / 10);
    localparam bcd_digit_t WRAP_ONES = bcd_digit_t'((MODULUS - 1) % 10);
    localparam logic [7:0] MOD_BIN   = 8'(MODULUS);

    bcd_digit_t tens_r;
    bcd_digit_t ones_r;
    bcd_digit_t tens_next_s;
    bcd_digit_t ones_next_s;
    logic       at_zero_s;
    logic       at_max_s;
    logic       load_ok_s;
    logic       borrow_d_s;
    logic       load_err_d_s;

    assign at_zero_s    = (tens_r == 4'd0) && (ones_r == 4'd0);
    assign at_max_s     = (tens_r == WRAP_TENS) && (ones_r == WRAP_ONES);
    assign load_ok_s    = is_bcd(load_tens) && is_bcd(load_ones) &&
                          (bcd_to_bin(load_tens, load_ones) < MOD_BIN);
    assign borrow_d_s   = at_zero_s && en && !inc && !load;
    assign load_err_d_s = load && !load_ok_s;

    // Digit next-state: load beats en beats hold; illegal loads clamp to the wrap value.
    always_comb begin
        tens_next_s = tens_r;
        ones_next_s = ones_r;
        if (load) begin
            if (load_ok_s) begin
                tens_next_s = load_tens;
                ones_next_s = load_ones;
            end else begin
                tens_next_s = WRAP_TENS;
                ones_next_s = WRAP_ONES;
            end
        end else if (en) begin
            if (!inc) begin
                if (at_zero_s) begin
                    tens_next_s = WRAP_TENS;
                    ones_next_s = WRAP_ONES;
                end else if (ones_r != 4'd0) begin
                    ones_next_s = ones_r - 4'd1;
                end else begin
                    ones_next_s = 4'd9;
                    tens_next_s = tens_r - 4'd1;
                end
            end else begin
                if (at_max_s) begin
                    tens_next_s = 4'd0;
                    ones_next_s = 4'd0;
                end else if (ones_r != 4'd9) begin
                    ones_next_s = ones_r + 4'd1;
                end else begin
                    ones_next_s = 4'd0;
                    tens_next_s = tens_r + 4'd1;
                end
            end
        end else begin
            tens_next_s = tens_r;
            ones_next_s = ones_r;
        end
    end

    // Digit state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tens_r <= 4'd0;
            ones_r <= 4'd0;
        end else begin
            tens_r <= tens_next_s;
            ones_r <= ones_next_s;
        end
    end

    delay_ff #(.WIDTH(1)) u_borrow_ff (
        .clk   (clk),
        .reset (reset),
        .d     (borrow_d_s),
        .q     (borrow)
    );

    delay_ff #(.WIDTH(1)) u_load_err_ff (
        .clk   (clk),
        .reset (reset),
        .d     (load_err_d_s),
        .q     (load_err)
    );

    assign tens = tens_r;
    assign ones = ones_r;

endmodule

// File: tb/tb_bcd_down_counter.sv
// Directed self-checking bench: a MODULUS=24 counter plus a 60->24 borrow cascade.
module tb_bcd_down_counter;

    logic       clk;
    logic       reset;
    logic       en;
    logic       inc;
    logic       load;
    logic [3:0] load_ones;
    logic [3:0] load_tens;
    logic [3:0] ones;
    logic [3:0] tens;
    logic       borrow;
    logic       load_err;

    logic       tick;
    logic [3:0] min_ones, min_tens, hr_ones, hr_tens;
    logic       min_borrow, min_load_err, hr_borrow, hr_load_err;

    int n_cmp = 0;
    int n_err = 0;

    bcd_down_counter #(.MODULUS(24)) dut (
        .clk(clk), .reset(reset), .en(en), .inc(inc), .load(load),
        .load_ones(load_ones), .load_tens(load_tens),
        .ones(ones), .tens(tens), .borrow(borrow), .load_err(load_err)
    );

    bcd_down_counter #(.MODULUS(60)) u_min (
        .clk(clk), .reset(reset), .en(tick), .inc(1'b0), .load(1'b0),
        .load_ones(4'd0), .load_tens(4'd0),
        .ones(min_ones), .tens(min_tens), .borrow(min_borrow), .load_err(min_load_err)
    );

    bcd_down_counter #(.MODULUS(24)) u_hr (
        .clk(clk), .reset(reset), .en(min_borrow), .inc(1'b0), .load(1'b0),
        .load_ones(4'd0), .load_tens(4'd0),
        .ones(hr_ones), .tens(hr_tens), .borrow(hr_borrow), .load_err(hr_load_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [3:0] t, input logic [3:0] o);
        load      = 1'b1;
        load_tens = t;
        load_ones = o;
        step();
        load      = 1'b0;
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; inc = 1'b0; load = 1'b0;
        load_ones = 4'd0; load_tens = 4'd0; tick = 1'b0;
        step(); step();
        check("rst_count", {tens, ones}, 8'h00);
        check("rst_borrow", {7'd0, borrow}, 8'h00);
        check("rst_load_err", {7'd0, load_err}, 8'h00);
        reset = 1'b0;
        step();
        check("hold_after_rst", {tens, ones}, 8'h00);

        // First down step wraps to 23 with a single borrow pulse.
        en = 1'b1;
        step();
        check("wrap_count", {tens, ones}, 8'h23);
        check("wrap_borrow", {7'd0, borrow}, 8'h01);
        step();
        check("down_22", {tens, ones}, 8'h22);
        check("borrow_drop", {7'd0, borrow}, 8'h00);
        en = 1'b0;
        step();
        check("hold_22", {tens, ones}, 8'h22);

        // Load 10 then tens borrow across the digit boundary.
        do_load(4'd1, 4'd0);
        check("load_10", {tens, ones}, 8'h10);
        check("load_10_err", {7'd0, load_err}, 8'h00);
        en = 1'b1;
        step();
        check("down_09", {tens, ones}, 8'h09);
        check("down_09_borrow", {7'd0, borrow}, 8'h00);
        step();
        check("down_08", {tens, ones}, 8'h08);
        check("down_08_borrow", {7'd0, borrow}, 8'h00);
        en = 1'b0;

        // Up-wrap from 23 to 00 without borrow.
        do_load(4'd2, 4'd3);
        check("load_23", {tens, ones}, 8'h23);
        en = 1'b1; inc = 1'b1;
        step();
        check("upwrap_00", {tens, ones}, 8'h00);
        check("upwrap_borrow", {7'd0, borrow}, 8'h00);
        step();
        check("up_01", {tens, ones}, 8'h01);
        do_load(4'd0, 4'd9);
        step();
        check("up_carry_10", {tens, ones}, 8'h10);
        en = 1'b0; inc = 1'b0;

        // Illegal loads clamp to 23 with a one-cycle load_err.
        do_load(4'd2, 4'd7);
        check("clamp_27", {tens, ones}, 8'h23);
        check("clamp_27_err", {7'd0, load_err}, 8'h01);
        step();
        check("load_err_one_cycle", {7'd0, load_err}, 8'h00);
        do_load(4'd1, 4'd2);
        do_load(4'd0, 4'hA);
        check("clamp_0A", {tens, ones}, 8'h23);
        check("clamp_0A_err", {7'd0, load_err}, 8'h01);
        do_load(4'd1, 4'd5);
        check("load_15", {tens, ones}, 8'h15);
        check("load_15_err", {7'd0, load_err}, 8'h00);

        // At zero, load beats en and suppresses borrow.
        do_load(4'd0, 4'd0);
        check("load_00", {tens, ones}, 8'h00);
        en = 1'b1;
        do_load(4'd0, 4'd5);
        check("load_over_en", {tens, ones}, 8'h05);
        check("load_over_en_borrow", {7'd0, borrow}, 8'h00);
        en = 1'b0;

        // Async reset between edges clears state and a live borrow pulse.
        do_load(4'd0, 4'd0);
        en = 1'b1;
        step();
        check("pre_rst_borrow", {7'd0, borrow}, 8'h01);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_count", {tens, ones}, 8'h00);
        check("async_rst_borrow", {7'd0, borrow}, 8'h00);
        en = 1'b0;
        step();
        reset = 1'b0;
        step();

        // Cascade: minutes borrow drives hours en one cycle later.
        tick = 1'b1;
        step();
        tick = 1'b0;
        check("casc_min_59", {min_tens, min_ones}, 8'h59);
        check("casc_hr_hold", {hr_tens, hr_ones}, 8'h00);
        step();
        check("casc_hr_23", {hr_tens, hr_ones}, 8'h23);
        check("casc_min_hold", {min_tens, min_ones}, 8'h59);
        tick = 1'b1;
        for (int i = 0; i < 60; i++) step();
        tick = 1'b0;
        check("casc_min_59b", {min_tens, min_ones}, 8'h59);
        check("casc_min_borrow", {7'd0, min_borrow}, 8'h01);
        step();
        check("casc_hr_22", {hr_tens, hr_ones}, 8'h22);
        check("casc_hr_borrow", {7'd0, hr_borrow}, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
